// File: rtl/if_stage_ibuf_if.sv
// Handshake and data bundle between pre-IF, inst cache, IF buffer and decode.
// The IF stage uses the slave modport; its environment uses master.
interface if_stage_ibuf_if #(
   parameter int PF_TO_FS_BUS_WD = 39,
   parameter int FS_TO_DS_BUS_WD = 71
);
   logic                       pfs_to_fs_valid;
   logic [PF_TO_FS_BUS_WD-1:0] preif_to_fs_bus;
   logic                       fs_allowin;
   logic [4:0]                 inst_offset;
   logic                       inst_cache_data_ok;
   logic [127:0]               inst_cache_rdata;
   logic                       fs_reflush;
   logic                       ds_allowin;
   logic                       fs_to_ds_valid;
   logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;

   modport master (
      output pfs_to_fs_valid, preif_to_fs_bus, inst_cache_data_ok, inst_cache_rdata,
      output fs_reflush, ds_allowin,
      input  fs_allowin, inst_offset, fs_to_ds_valid, fs_to_ds_bus
   );

   modport slave (
      input  pfs_to_fs_valid, preif_to_fs_bus, inst_cache_data_ok, inst_cache_rdata,
      input  fs_reflush, ds_allowin,
      output fs_allowin, inst_offset, fs_to_ds_valid, fs_to_ds_bus
   );
endinterface

// File: rtl/if_stage_ibuf.sv
// IF stage: in-order matching of fetch requests to 128-bit cache lines,
// feeding an instruction queue that hands one instruction per cycle to decode.
module if_stage_ibuf #(
   parameter int IQ_DEPTH = 8
) (
   input  logic           clk,
   input  logic           reset,
   if_stage_ibuf_if.slave fs
);
   localparam int PTR_W  = $clog2(IQ_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int FREE_W = CNT_W + 1;

   logic [31:0]      pend_pc_reg   [2];
   logic             pend_exc_reg  [2];
   logic [4:0]       pend_type_reg [2];
   logic             pend_tlb_reg  [2];
   logic             pend_head_reg, pend_head_next;
   logic [1:0]       pend_cnt_reg, pend_cnt_next;
   logic [1:0]       cancel_cnt_reg, cancel_cnt_next;
   logic [1:0]       off_lo_reg;
   logic [70:0]      iq_mem [IQ_DEPTH];
   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next, wr_ptr_reg, wr_ptr_next;
   logic [CNT_W-1:0] iq_count_reg, iq_count_next;

   logic        accept, pop, has_head, exc_take, resp_take, head_pop;
   logic        pend_tail, allow_normal, allow_flush;
   logic [31:0] h_pc;
   logic        h_exc, h_tlb;
   logic [4:0]  h_type;
   logic [2:0]  wr_cnt, cancel_flush;
   logic [1:0]  nonexc_pend;
   logic [FREE_W-1:0] iq_free;
   logic [3:0]  lane_en;
   logic [70:0] lane_data [4];

   assign h_pc   = pend_pc_reg[pend_head_reg];
   assign h_exc  = pend_exc_reg[pend_head_reg];
   assign h_type = pend_type_reg[pend_head_reg];
   assign h_tlb  = pend_tlb_reg[pend_head_reg];

   assign has_head  = pend_cnt_reg != 2'd0;
   assign exc_take  = has_head & h_exc & ~fs.fs_reflush;
   assign resp_take = fs.inst_cache_data_ok & (cancel_cnt_reg == 2'd0) & has_head & ~h_exc
                      & ~fs.fs_reflush;
   assign head_pop  = exc_take | resp_take;
   assign wr_cnt    = resp_take ? (3'd4 - {1'b0, h_pc[3:2]}) : {2'b00, exc_take};

   assign fs.fs_to_ds_valid = (iq_count_reg != '0) & ~fs.fs_reflush;
   assign fs.fs_to_ds_bus   = iq_mem[rd_ptr_reg];
   assign fs.inst_offset    = 5'd16 - {1'b0, off_lo_reg, 2'b00};
   assign pop               = fs.fs_to_ds_valid & fs.ds_allowin;
   assign accept            = fs.pfs_to_fs_valid & fs.fs_allowin;

   always_comb begin
      nonexc_pend = 2'd0;
      for (int i = 0; i < 2; i++)
         if (2'(i) < pend_cnt_reg && !pend_exc_reg[pend_head_reg ^ 1'(i)])
            nonexc_pend = nonexc_pend + 2'd1;
   end

   // Every issued non-exception request still owes a response; on flush they become drops.
   assign cancel_flush = {1'b0, cancel_cnt_reg} + {1'b0, nonexc_pend}
                         - {2'b00, fs.inst_cache_data_ok};
   assign iq_free      = FREE_W'(IQ_DEPTH) - FREE_W'(iq_count_reg) + FREE_W'(pop);
   assign allow_normal = ({1'b0, pend_cnt_reg} + {1'b0, cancel_cnt_reg} < 3'd2)
                         & (iq_free >= FREE_W'({pend_cnt_reg + 2'd1, 2'b00}));
   // In the flush cycle the IQ and pending FIFO empty, so only the drop count limits the
   // reflush-pc request; it is capped so no more than three responses are ever owed.
   assign allow_flush  = cancel_flush <= 3'd2;
   assign fs.fs_allowin = fs.fs_reflush ? allow_flush : allow_normal;

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [2:0] widx;
      assign widx = {1'b0, h_pc[3:2]} + 3'(gi);
      assign lane_en[gi] = resp_take ? (widx < 3'd4) : ((gi == 0) && exc_take);
      assign lane_data[gi] = exc_take
         ? {h_tlb, 1'b1, h_type, h_pc, 32'h0}
         : {2'b00, 5'h00, h_pc + 32'(4 * gi), fs.inst_cache_rdata[32*widx[1:0] +: 32]};
   end

   always_comb begin
      pend_tail       = pend_head_reg ^ pend_cnt_reg[0];
      pend_head_next  = pend_head_reg ^ head_pop;
      pend_cnt_next   = pend_cnt_reg + {1'b0, accept} - {1'b0, head_pop};
      cancel_cnt_next = cancel_cnt_reg
                        - {1'b0, fs.inst_cache_data_ok & (cancel_cnt_reg != 2'd0)};
      rd_ptr_next     = rd_ptr_reg + PTR_W'(pop);
      wr_ptr_next     = wr_ptr_reg + PTR_W'(wr_cnt);
      iq_count_next   = iq_count_reg + CNT_W'(wr_cnt) - CNT_W'(pop);
      if (fs.fs_reflush) begin
         pend_tail       = 1'b0;
         pend_head_next  = 1'b0;
         pend_cnt_next   = {1'b0, accept};
         cancel_cnt_next = cancel_flush[1:0];
         rd_ptr_next     = '0;
         wr_ptr_next     = '0;
         iq_count_next   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_head_reg  <= 1'b0;
         pend_cnt_reg   <= 2'd0;
         cancel_cnt_reg <= 2'd0;
         off_lo_reg     <= 2'b11;
         rd_ptr_reg     <= '0;
         wr_ptr_reg     <= '0;
         iq_count_reg   <= '0;
      end else begin
         pend_head_reg  <= pend_head_next;
         pend_cnt_reg   <= pend_cnt_next;
         cancel_cnt_reg <= cancel_cnt_next;
         rd_ptr_reg     <= rd_ptr_next;
         wr_ptr_reg     <= wr_ptr_next;
         iq_count_reg   <= iq_count_next;
         if (accept)
            off_lo_reg <= fs.preif_to_fs_bus[3:2];
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         pend_pc_reg[pend_tail]   <= fs.preif_to_fs_bus[31:0];
         pend_type_reg[pend_tail] <= fs.preif_to_fs_bus[36:32];
         pend_exc_reg[pend_tail]  <= fs.preif_to_fs_bus[37];
         pend_tlb_reg[pend_tail]  <= fs.preif_to_fs_bus[38];
      end
      for (int i = 0; i < 4; i++)
         if (lane_en[i])
            iq_mem[wr_ptr_reg + PTR_W'(i)] <= lane_data[i];
   end

   a_resp_has_owner: assert property (@(posedge clk) disable iff (reset)
      (fs.inst_cache_data_ok && cancel_cnt_reg == 2'd0) |-> (has_head && !h_exc));

   a_iq_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !fs.fs_reflush |-> ({1'b0, iq_count_reg} + FREE_W'(wr_cnt) - FREE_W'(pop))
                         <= FREE_W'(IQ_DEPTH));
endmodule
